// File: rtl/hunt_pkg.sv
// rtl/hunt_pkg.sv - shared types and constants for the hunt-the-bit session sequencer
// Contents:
//   CLOCK_FREQ_HZ   system clock frequency, default tick period source
//   DEFAULT_LIVES   default number of rounds per session
//   session_state_t sequencer state encoding (3 bits, shown on debug LEDs)
package hunt_pkg;

    localparam int CLOCK_FREQ_HZ = 100_000_000;
    localparam int DEFAULT_LIVES = 3;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        COUNTDOWN    = 3'd1,
        PLAY         = 3'd2,
        ROUND_END    = 3'd3,
        SESSION_OVER = 3'd4
    } session_state_t;

endpackage

// File: rtl/hunt_session_ctrl_tick_gen.sv
// rtl/hunt_session_ctrl_tick_gen.sv - restartable prescaler producing a one-cycle tick
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset
//   restart  clears the prescaler; the next tick is then TickCycles cycles away
//   tick     single-cycle pulse every TickCycles cycles
module tick_gen
    import hunt_pkg::*;
#(
    parameter int TickCycles = CLOCK_FREQ_HZ
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CntW = (TickCycles > 1) ? $clog2(TickCycles) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(TickCycles - 1);

    logic [CntW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            cnt <= '0;
        end else if (cnt == LastCnt) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CntW'(1);
        end
    end

    // Decoded from the counter so the tick never combinationally depends on restart.
    assign tick = (cnt == LastCnt);

endmodule

// File: rtl/hunt_session_ctrl.sv
// rtl/hunt_session_ctrl.sv - session sequencer: round reset, countdown, lives, score and display select
// Optional build macro: HUNT_SESSION_ATTRACT_EN (IDLE display alternates last total / best each tick)
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   start_btn       debounced start switch (level, rising edge used in IDLE only)
//   game_lost       core lose-state level (rising edge used in PLAY only)
//   game_points     core's current point count
//   game_rst        registered reset to the game core (low only in PLAY)
//   countdown       remaining countdown ticks, 0 outside COUNTDOWN
//   lives           lives remaining in the session
//   best_points     best completed-session total
//   display_points  value routed to the 7-segment driver
//   show_best       high when display_points is best_points
//   session_state   current state encoding
module hunt_session_ctrl
    import hunt_pkg::*;
#(
    parameter int TickCycles     = CLOCK_FREQ_HZ,
    parameter int NumLives       = DEFAULT_LIVES,
    parameter int CountdownTicks = 3,
    parameter int HoldTicks      = 5,
    parameter int PointsWidth    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_btn,
    input  logic                   game_lost,
    input  logic [PointsWidth-1:0] game_points,
    output logic                   game_rst,
    output logic [3:0]             countdown,
    output logic [2:0]             lives,
    output logic [PointsWidth-1:0] best_points,
    output logic [PointsWidth-1:0] display_points,
    output logic                   show_best,
    output logic [2:0]             session_state
);

    localparam logic [2:0] LivesInit = 3'(NumLives);
    localparam logic [3:0] CdInit    = 4'(CountdownTicks);
    localparam logic [3:0] HoldLast  = 4'(HoldTicks - 1);

    session_state_t         state;
    session_state_t         next_state;
    logic                   start_q;
    logic                   lost_q;
    logic                   start_edge;
    logic                   lost_edge;
    logic                   tick;
    logic                   restart;
    logic [3:0]             hold_cnt;
    logic [PointsWidth-1:0] total;
    logic [PointsWidth-1:0] live_total;

    function automatic logic [PointsWidth-1:0] sat_add(input logic [PointsWidth-1:0] a,
                                                       input logic [PointsWidth-1:0] b);
        logic [PointsWidth:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[PointsWidth] ? '1 : s[PointsWidth-1:0];
    endfunction

    assign start_edge    = start_btn & ~start_q;
    assign lost_edge     = game_lost & ~lost_q;
    assign live_total    = sat_add(total, game_points);
    assign session_state = state;

    // Prescaler restarts on the same edge the state changes, so every state
    // sees its first tick a full TickCycles after entry.
    assign restart = (next_state != state);

    tick_gen #(
        .TickCycles(TickCycles)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .restart(restart),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start_edge) next_state = COUNTDOWN;
            end
            COUNTDOWN: begin
                if (tick && countdown == 4'd1) next_state = PLAY;
            end
            PLAY: begin
                if (lost_edge) next_state = ROUND_END;
            end
            ROUND_END: begin
                next_state = (lives == 3'd0) ? SESSION_OVER : COUNTDOWN;
            end
            SESSION_OVER: begin
                if (tick && hold_cnt == HoldLast) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            start_q     <= 1'b0;
            lost_q      <= 1'b0;
            game_rst    <= 1'b1;
            countdown   <= 4'd0;
            hold_cnt    <= 4'd0;
            lives       <= LivesInit;
            total       <= '0;
            best_points <= '0;
        end else begin
            start_q  <= start_btn;
            lost_q   <= game_lost;
            // Registered from next_state so the core leaves reset on the PLAY entry edge.
            game_rst <= (next_state != PLAY);

            if (next_state == COUNTDOWN) begin
                if (state != COUNTDOWN) begin
                    countdown <= CdInit;
                end else if (tick) begin
                    countdown <= countdown - 4'd1;
                end
            end else begin
                countdown <= 4'd0;
            end

            if (state != SESSION_OVER) begin
                hold_cnt <= 4'd0;
            end else if (tick) begin
                hold_cnt <= hold_cnt + 4'd1;
            end

            case (state)
                IDLE: begin
                    if (start_edge) begin
                        lives <= LivesInit;
                        total <= '0;
                    end
                end
                PLAY: begin
                    if (lost_edge) begin
                        total <= live_total;
                        lives <= lives - 3'd1;
                    end
                end
                ROUND_END: begin
                    // Only the final round of a session can promote its total.
                    if (lives == 3'd0 && total > best_points) begin
                        best_points <= total;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef HUNT_SESSION_ATTRACT_EN
    logic attract_best;

    // Re-armed to "best" outside IDLE so every IDLE visit opens on the best score.
    always_ff @(posedge clk) begin
        if (rst) begin
            attract_best <= 1'b1;
        end else if (state != IDLE) begin
            attract_best <= 1'b1;
        end else if (tick) begin
            attract_best <= ~attract_best;
        end
    end
`endif

    always_comb begin
        display_points = total;
        show_best      = 1'b0;
        case (state)
            PLAY: begin
                display_points = live_total;
            end
            IDLE: begin
`ifdef HUNT_SESSION_ATTRACT_EN
                if (attract_best) begin
                    display_points = best_points;
                    show_best      = 1'b1;
                end
`else
                display_points = best_points;
                show_best      = 1'b1;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_hunt_session_ctrl.sv
// tb/tb_hunt_session_ctrl.sv - scoreboard bench for hunt_session_ctrl
module tb_hunt_session_ctrl;
    import hunt_pkg::*;

    localparam int TC = 4;
    localparam int NL = 2;
    localparam int CD = 3;
    localparam int HT = 2;
    localparam int PW = 32;

    logic          clk;
    logic          rst;
    logic          start_btn;
    logic          game_lost;
    logic [PW-1:0] game_points;
    logic          game_rst;
    logic [3:0]    countdown;
    logic [2:0]    lives;
    logic [PW-1:0] best_points;
    logic [PW-1:0] display_points;
    logic          show_best;
    logic [2:0]    session_state;

    hunt_session_ctrl #(
        .TickCycles    (TC),
        .NumLives      (NL),
        .CountdownTicks(CD),
        .HoldTicks     (HT),
        .PointsWidth   (PW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_btn     (start_btn),
        .game_lost     (game_lost),
        .game_points   (game_points),
        .game_rst      (game_rst),
        .countdown     (countdown),
        .lives         (lives),
        .best_points   (best_points),
        .display_points(display_points),
        .show_best     (show_best),
        .session_state (session_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_total = 0;
    int   n_fail  = 0;
    int   n;

    task automatic step(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input logic [63:0] obs);
        exp_t e;
        n_total++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $error("FAIL sb_empty observed=%0h expected=<none>", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        sb_push(tag, exp);
        sb_check(obs);
    endtask

    task automatic wait_state(input logic [2:0] tgt, input int maxc, output int cycles);
        cycles = 0;
        while (session_state !== tgt && cycles < maxc) begin
            step(1);
            cycles++;
        end
    endtask

    // Expectations are queued with the lose stimulus and drained as the DUT responds.
    task automatic lose_round(input logic [PW-1:0] pts, input logic [PW-1:0] exp_total,
                              input logic [2:0] exp_lives);
        game_points = pts;
        game_lost   = 1'b1;
        sb_push("play_display", exp_total);
        sb_push("re_state", ROUND_END);
        sb_push("re_game_rst", 1);
        sb_push("re_total", exp_total);
        sb_push("re_lives", exp_lives);
        #1;
        sb_check(display_points);
        step(1);
        sb_check(session_state);
        sb_check(game_rst);
        sb_check(display_points);
        sb_check(lives);
        game_lost = 1'b0;
    endtask

    task automatic start_session();
        start_btn = 1'b1;
        step(1);
        chk("start_state", session_state, COUNTDOWN);
        chk("start_total", display_points, 0);
        chk("start_lives", lives, NL);
        chk("start_cd", countdown, CD);
        start_btn = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        start_btn   = 1'b0;
        game_lost   = 1'b0;
        game_points = '0;
        step(2);
        rst = 1'b0;
        chk("rst_state", session_state, IDLE);
        chk("rst_game_rst", game_rst, 1);
        chk("rst_cd", countdown, 0);
        chk("rst_lives", lives, NL);
        chk("rst_best", best_points, 0);
        chk("rst_display", display_points, 0);
        chk("rst_show_best", show_best, 1);

        // Session 1: countdown timing, rounds of 5 and 7.
        start_session();
        step(4);
        chk("cd_2", countdown, 2);
        step(4);
        chk("cd_1", countdown, 1);
        step(3);
        chk("cd_last_state", session_state, COUNTDOWN);
        chk("cd_last_game_rst", game_rst, 1);
        step(1);
        chk("play_entry_state", session_state, PLAY);
        chk("play_entry_game_rst", game_rst, 0);
        chk("play_entry_cd", countdown, 0);

        lose_round(5, 5, 1);
        step(1);
        chk("r1_next_state", session_state, COUNTDOWN);
        chk("r1_next_game_rst", game_rst, 1);
        wait_state(PLAY, 40, n);
        chk("r2_cd_cycles", n, 12);
        lose_round(7, 12, 0);
        chk("r2_best_before", best_points, 0);
        step(1);
        chk("so_state", session_state, SESSION_OVER);
        chk("so_best", best_points, 12);
        chk("so_display", display_points, 12);
        wait_state(IDLE, 40, n);
        chk("so_cycles", n, 8);
        chk("idle_display", display_points, 12);
        chk("idle_show_best", show_best, 1);

        // Session 2: total 9 does not beat 12; start edges outside IDLE ignored.
        start_session();
        wait_state(PLAY, 40, n);
        chk("s2_cd_cycles", n, 12);
        start_btn = 1'b1;
        step(1);
        chk("s2_start_in_play", session_state, PLAY);
        start_btn = 1'b0;
        lose_round(4, 4, 1);
        step(1);
        wait_state(PLAY, 40, n);
        lose_round(5, 9, 0);
        step(1);
        chk("s2_so_state", session_state, SESSION_OVER);
        start_btn = 1'b1;
        step(1);
        chk("s2_start_in_so", session_state, SESSION_OVER);
        start_btn = 1'b0;
        wait_state(IDLE, 40, n);
        chk("s2_so_cycles", n, 7);
        chk("s2_best", best_points, 12);
        chk("s2_idle_display", display_points, 12);

        // Session 3: saturation of the running total.
        start_session();
        wait_state(PLAY, 40, n);
        lose_round(32'hFFFF_FFF0, 32'hFFFF_FFF0, 1);
        step(1);
        wait_state(PLAY, 40, n);
        lose_round(32'h20, 32'hFFFF_FFFF, 0);
        step(1);
        chk("s3_best", best_points, 32'hFFFF_FFFF);
        wait_state(IDLE, 40, n);
        chk("s3_so_cycles", n, 8);

        // IDLE display select across ticks.
        chk("attract_0", show_best, 1);
        step(4);
`ifdef HUNT_SESSION_ATTRACT_EN
        chk("attract_1", show_best, 0);
`else
        chk("attract_1", show_best, 1);
`endif
        step(4);
        chk("attract_2", show_best, 1);
        chk("attract_2_display", display_points, 32'hFFFF_FFFF);

        // Session 4: reset mid-PLAY clears everything including best.
        start_session();
        wait_state(PLAY, 40, n);
        chk("s4_play", session_state, PLAY);
        game_points = 3;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("mid_rst_state", session_state, IDLE);
        chk("mid_rst_game_rst", game_rst, 1);
        chk("mid_rst_lives", lives, NL);
        chk("mid_rst_best", best_points, 0);
        chk("mid_rst_display", display_points, 0);
        chk("mid_rst_show_best", show_best, 1);

        chk("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

endmodule
